fifo_rd_ctrl: RTL and testbench

//  Read-domain controller of the asynchronous FIFO; counterpart to the write-side memory/pointer logic.

---
 rtl/fifo_rd_ctrl_if.sv | 59 +++++
 rtl/fifo_rd_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_if
// Bundles the read-domain signals of the asynchronous FIFO read controller.
//
// Ports and signals:
//   wr_ptr_gray  Gray write pointer from the write domain (asynchronous)
//   rd_mem_data  memory read data, combinational from rd_addr
//   rd_addr      memory read address
//   rd_ptr_gray  registered Gray read pointer, towards the write domain
//   rd_empty     memory holds no unread word
//   rd_level     number of unread words in memory
//   rd_data      output register contents
//   rd_valid     rd_data holds a word
//   rd_ready     consumer accepts rd_data this cycle
//
// Modports:
//   master  the read controller
//   slave   the memory and consumer around it
// -----------------------------------------------------------------------------
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
);

  logic [ADD_WIDTH:0]    wr_ptr_gray;
  logic [DATA_WIDTH-1:0] rd_mem_data;
  logic [ADD_WIDTH-1:0]  rd_addr;
  logic [ADD_WIDTH:0]    rd_ptr_gray;
  logic                  rd_empty;
  logic [ADD_WIDTH:0]    rd_level;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  modport master (
    input  wr_ptr_gray,
    input  rd_mem_data,
    input  rd_ready,
    output rd_addr,
    output rd_ptr_gray,
    output rd_empty,
    output rd_level,
    output rd_data,
    output rd_valid
  );

  modport slave (
    output wr_ptr_gray,
    output rd_mem_data,
    output rd_ready,
    input  rd_addr,
    input  rd_ptr_gray,
    input  rd_empty,
    input  rd_level,
    input  rd_data,
    input  rd_valid
  );

endinterface

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-domain controller of an asynchronous FIFO. Synchronises the write Gray
// pointer into rd_clk, keeps the binary and Gray read pointers, derives the
// empty flag and fill level, and presents words through a one-entry
// show-ahead output register with a valid/ready handshake.
//
// Ports:
//   rd_clk   read-domain clock
//   rd_rst   asynchronous active-high reset
//   bus      fifo_rd_ctrl_if.master: wr_ptr_gray, rd_mem_data, rd_ready in;
//            rd_addr, rd_ptr_gray, rd_empty, rd_level, rd_data, rd_valid out
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 16,
  parameter int ADD_WIDTH   = $clog2(MEM_DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  fifo_rd_ctrl_if.master      bus
);

  localparam int PW = ADD_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{ADD_WIDTH{1'b0}}, 1'b1};

  // Binary to Gray: adjacent codes differ in exactly one bit.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         rd_ptr_bin_q;
  logic [PW-1:0]         rd_ptr_bin_d;
  logic [PW-1:0]         rd_ptr_gray_q;
  logic [PW-1:0]         rd_ptr_gray_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  rd_valid_q;
  logic                  rd_valid_d;

  logic [PW-1:0]         wq_ptr_gray;
  logic                  empty;
  logic [PW-1:0]         level;
  logic                  load;

  assign wq_ptr_gray = sync_q[SYNC_STAGES-1];

  // Write-pointer synchroniser chain; the only consumer of wr_ptr_gray.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= PTR_ZERO;
      end
    end else begin
      sync_q[0] <= bus.wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Status flags, load decision and next state of pointers/output register.
  always_comb begin
    empty         = (rd_ptr_gray_q == wq_ptr_gray);
    // Modulo subtraction: the synced write pointer lags, so the level can only
    // under-report.
    level         = gray2bin(wq_ptr_gray) - rd_ptr_bin_q;
    // Fetch when memory has a word and the output register is free or being
    // drained this cycle; an empty memory never advances the pointer.
    load          = !empty && (!rd_valid_q || bus.rd_ready);
    rd_ptr_bin_d  = rd_ptr_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    if (load) begin
      rd_ptr_bin_d  = rd_ptr_bin_q + PTR_ONE;
      rd_ptr_gray_d = bin2gray(rd_ptr_bin_q + PTR_ONE);
      rd_data_d     = bus.rd_mem_data;
      rd_valid_d    = 1'b1;
    end else if (rd_valid_q && bus.rd_ready) begin
      rd_valid_d    = 1'b0;
    end else begin
      rd_valid_d    = rd_valid_q;
    end
  end

  // Read pointers and show-ahead output register.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_bin_q  <= PTR_ZERO;
      rd_ptr_gray_q <= PTR_ZERO;
      rd_data_q     <= {DATA_WIDTH{1'b0}};
      rd_valid_q    <= 1'b0;
    end else begin
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // rd_ptr_gray comes straight from a flop so the write domain never sees a
  // glitch; the memory address is the low part of the binary pointer.
  assign bus.rd_addr     = rd_ptr_bin_q[ADD_WIDTH-1:0];
  assign bus.rd_ptr_gray = rd_ptr_gray_q;
  assign bus.rd_empty    = empty;
  assign bus.rd_level    = level;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Directed bench for fifo_rd_ctrl: models the FIFO memory and the write
// pointer, drives rd_ready and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] mem [MD];
  logic [AW:0]   wr_bin;
  int            tests_run    = 0;
  int            tests_failed = 0;

  always #5 clk = ~clk;

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ {1'b0, b[AW:1]};
  endfunction

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();

  assign bus.rd_mem_data = mem[bus.rd_addr];
  assign bus.wr_ptr_gray = bin2gray(wr_bin);

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (MD),
    .ADD_WIDTH  (AW),
    .SYNC_STAGES(2)
  ) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then return at the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    wr_bin       = 5'd0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits for the FIFO and the output register to drain, bounded.
  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (!(bus.rd_empty && !bus.rd_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", 32'(n < max_cycles), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < MD; i++) mem[i] = 8'h00;

    // Reset state
    do_reset();
    check_eq("rst_empty", 32'(bus.rd_empty), 32'd1);
    check_eq("rst_valid", 32'(bus.rd_valid), 32'd0);
    check_eq("rst_data",  32'(bus.rd_data), 32'h0);
    check_eq("rst_gray",  32'(bus.rd_ptr_gray), 32'h0);
    check_eq("rst_level", 32'(bus.rd_level), 32'd0);
    check_eq("rst_addr",  32'(bus.rd_addr), 32'd0);

    // Single word: two sync edges, then load on the third
    mem[0]       = 8'hA5;
    bus.rd_ready = 1'b1;
    wr_bin       = 5'd1;
    tick();
    check_eq("sw_empty_e1", 32'(bus.rd_empty), 32'd1);
    tick();
    check_eq("sw_empty_e2", 32'(bus.rd_empty), 32'd0);
    check_eq("sw_valid_e2", 32'(bus.rd_valid), 32'd0);
    check_eq("sw_level_e2", 32'(bus.rd_level), 32'd1);
    tick();
    check_eq("sw_valid_e3", 32'(bus.rd_valid), 32'd1);
    check_eq("sw_data_e3",  32'(bus.rd_data), 32'hA5);
    check_eq("sw_gray_e3",  32'(bus.rd_ptr_gray), 32'h1);
    check_eq("sw_empty_e3", 32'(bus.rd_empty), 32'd1);
    tick();
    check_eq("sw_valid_e4", 32'(bus.rd_valid), 32'd0);

    // Burst of a full memory
    do_reset();
    for (int i = 0; i < MD; i++) mem[i] = 8'(i);
    bus.rd_ready = 1'b1;
    wr_bin       = 5'd16;
    tick();
    tick();
    check_eq("bu_level_full", 32'(bus.rd_level), 32'd16);
    check_eq("bu_empty", 32'(bus.rd_empty), 32'd0);
    for (int k = 0; k < MD; k++) begin
      tick();
      check_eq("bu_valid", 32'(bus.rd_valid), 32'd1);
      check_eq("bu_data",  32'(bus.rd_data), 32'(k));
      check_eq("bu_level", 32'(bus.rd_level), 32'(15 - k));
    end
    tick();
    check_eq("bu_valid_end", 32'(bus.rd_valid), 32'd0);
    check_eq("bu_gray_end",  32'(bus.rd_ptr_gray), 32'h18);
    check_eq("bu_empty_end", 32'(bus.rd_empty), 32'd1);

    // Backpressure
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'h40 + i);
    bus.rd_ready = 1'b0;
    wr_bin       = 5'd4;
    tick();
    tick();
    tick();
    check_eq("bp_valid", 32'(bus.rd_valid), 32'd1);
    check_eq("bp_data",  32'(bus.rd_data), 32'h40);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("bp_hold_data",  32'(bus.rd_data), 32'h40);
      check_eq("bp_hold_valid", 32'(bus.rd_valid), 32'd1);
      check_eq("bp_hold_addr",  32'(bus.rd_addr), 32'd1);
      check_eq("bp_hold_gray",  32'(bus.rd_ptr_gray), 32'h1);
      check_eq("bp_hold_level", 32'(bus.rd_level), 32'd3);
    end
    bus.rd_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      check_eq("bp_b2b_data",  32'(bus.rd_data), 32'(8'h40 + j));
      check_eq("bp_b2b_valid", 32'(bus.rd_valid), 32'd1);
    end
    tick();
    check_eq("bp_valid_end", 32'(bus.rd_valid), 32'd0);
    check_eq("bp_empty_end", 32'(bus.rd_empty), 32'd1);
    check_eq("bp_gray_end",  32'(bus.rd_ptr_gray), 32'h6);

    // Wrap: advance the read pointer to 30, then read across the rollover
    wr_bin = 5'd20;
    tick();
    tick();
    tick();
    wait_idle(40);
    wr_bin = 5'd30;
    tick();
    tick();
    tick();
    wait_idle(40);
    check_eq("wr_addr_14", 32'(bus.rd_addr), 32'd14);
    check_eq("wr_gray_30", 32'(bus.rd_ptr_gray), 32'h11);
    bus.rd_ready = 1'b0;
    mem[14] = 8'hC0;
    mem[15] = 8'hC1;
    mem[0]  = 8'hC2;
    mem[1]  = 8'hC3;
    wr_bin  = 5'd2;
    tick();
    tick();
    check_eq("wr_level", 32'(bus.rd_level), 32'd4);
    tick();
    check_eq("wr_data0", 32'(bus.rd_data), 32'hC0);
    check_eq("wr_addr15", 32'(bus.rd_addr), 32'd15);
    check_eq("wr_gray31", 32'(bus.rd_ptr_gray), 32'h10);
    bus.rd_ready = 1'b1;
    tick();
    check_eq("wr_data1", 32'(bus.rd_data), 32'hC1);
    check_eq("wr_addr0", 32'(bus.rd_addr), 32'd0);
    check_eq("wr_gray0", 32'(bus.rd_ptr_gray), 32'h0);
    tick();
    check_eq("wr_data2", 32'(bus.rd_data), 32'hC2);
    check_eq("wr_addr1", 32'(bus.rd_addr), 32'd1);
    check_eq("wr_gray1", 32'(bus.rd_ptr_gray), 32'h1);
    tick();
    check_eq("wr_data3", 32'(bus.rd_data), 32'hC3);
    check_eq("wr_gray2", 32'(bus.rd_ptr_gray), 32'h3);
    tick();
    check_eq("wr_valid_end", 32'(bus.rd_valid), 32'd0);

    // Reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 10; i++) mem[i] = 8'(8'h80 + i);
    bus.rd_ready = 1'b1;
    wr_bin       = 5'd10;
    tick();
    tick();
    for (int k = 0; k < 5; k++) tick();
    check_eq("mr_data_pre", 32'(bus.rd_data), 32'h84);
    check_eq("mr_valid_pre", 32'(bus.rd_valid), 32'd1);
    rst    = 1'b1;
    wr_bin = 5'd0;
    #1;
    check_eq("mr_valid_async", 32'(bus.rd_valid), 32'd0);
    check_eq("mr_data_async",  32'(bus.rd_data), 32'h0);
    check_eq("mr_gray_async",  32'(bus.rd_ptr_gray), 32'h0);
    check_eq("mr_addr_async",  32'(bus.rd_addr), 32'd0);
    check_eq("mr_empty_async", 32'(bus.rd_empty), 32'd1);
    check_eq("mr_level_async", 32'(bus.rd_level), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check_eq("mr_valid_after", 32'(bus.rd_valid), 32'd0);
    check_eq("mr_empty_after", 32'(bus.rd_empty), 32'd1);
    check_eq("mr_data_after",  32'(bus.rd_data), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
